// File: rtl/cmd_cfg_wd.sv
// Command configuration unit for the copter. Decodes opcodes handed over by
// the UART wrapper, updates the flight setpoints, runs the battery conversion
// and inertial calibration sequences, returns a response byte and lands the
// craft if the command link goes quiet for too long.
//
// Handshakes: clr_cmd_rdy is combinational and high only while the FSM is
// IDLE and cmd_rdy is high, so the wrapper drops cmd_rdy on that same edge.
// send_resp, strt_cnv and strt_cal are registered single-cycle pulses. After
// send_resp the FSM sits in WAIT_TX until resp_sent, and no command is
// consumed there.
module cmd_cfg_wd #(
   parameter int TMR_W = 26,
   parameter int SP_W  = 16,
   parameter int THR_W = 9,
   parameter int WD_W  = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_rdy,
   input  logic [7:0]       cmd,
   input  logic [15:0]      data,
   output logic             clr_cmd_rdy,
   output logic [7:0]       resp,
   output logic             send_resp,
   input  logic             resp_sent,
   input  logic [7:0]       batt,
   output logic             strt_cnv,
   input  logic             cnv_cmplt,
   output logic             strt_cal,
   output logic             inertial_cal,
   input  logic             cal_done,
   output logic             motors_off,
   output logic [SP_W-1:0]  d_ptch,
   output logic [SP_W-1:0]  d_roll,
   output logic [SP_W-1:0]  d_yaw,
   output logic [THR_W-1:0] thrst,
   output logic             wd_trip
);

   localparam logic [7:0] REQ_BATT  = 8'h01;
   localparam logic [7:0] SET_PTCH  = 8'h02;
   localparam logic [7:0] SET_ROLL  = 8'h03;
   localparam logic [7:0] SET_YAW   = 8'h04;
   localparam logic [7:0] SET_THRST = 8'h05;
   localparam logic [7:0] CALIBRATE = 8'h06;
   localparam logic [7:0] EMER_LAND = 8'h07;
   localparam logic [7:0] MTRS_OFF  = 8'h08;
   localparam logic [7:0] ACK       = 8'hA5;
   localparam logic [7:0] NACK      = 8'hEE;

   localparam logic [TMR_W-1:0] TMR_MAX = '1;
   localparam logic [TMR_W-1:0] TMR_ONE = 1;
   localparam logic [WD_W-1:0]  WD_MAX  = '1;
   localparam logic [WD_W-1:0]  WD_PRE  = {{(WD_W-1){1'b1}}, 1'b0};
   localparam logic [WD_W-1:0]  WD_ONE  = 1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      BATT    = 3'd1,
      SPIN    = 3'd2,
      CAL     = 3'd3,
      WAIT_TX = 3'd4
   } state_t;

   state_t           state;
   logic [TMR_W-1:0] tmr;
   logic [WD_W-1:0]  wd_cnt;
   logic             accept;
   logic             wd_run;
   logic             wd_hit;

   // A command is taken only from IDLE; accepting it clears the watchdog.
   assign accept      = (state == IDLE) && cmd_rdy;
   assign clr_cmd_rdy = accept;

   // The watchdog only ages while waiting on the link with motors running;
   // the trip fires on the edge where the counter lands on all-ones and keeps
   // the setpoints pinned at zero while it stays saturated.
   assign wd_run = !motors_off && !accept && ((state == IDLE) || (state == WAIT_TX));
   assign wd_hit = wd_run && (wd_cnt >= WD_PRE);

   // Link-loss watchdog counter: cleared by commands and while motors are off.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_cnt <= '0;
      end else if (motors_off || accept) begin
         wd_cnt <= '0;
      end else if (wd_run && (wd_cnt != WD_MAX)) begin
         wd_cnt <= wd_cnt + WD_ONE;
      end
   end

   // Command FSM with registered setpoints, response and sequencing pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         tmr          <= '0;
         resp         <= 8'h00;
         send_resp    <= 1'b0;
         strt_cnv     <= 1'b0;
         strt_cal     <= 1'b0;
         inertial_cal <= 1'b0;
         motors_off   <= 1'b1;
         d_ptch       <= '0;
         d_roll       <= '0;
         d_yaw        <= '0;
         thrst        <= '0;
         wd_trip      <= 1'b0;
      end else begin
         send_resp <= 1'b0;
         strt_cnv  <= 1'b0;
         strt_cal  <= 1'b0;
         if (wd_hit) begin
            d_ptch  <= '0;
            d_roll  <= '0;
            d_yaw   <= '0;
            thrst   <= '0;
            wd_trip <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (cmd_rdy) begin
                  wd_trip <= 1'b0;
                  case (cmd)
                     REQ_BATT: begin
                        strt_cnv <= 1'b1;
                        state    <= BATT;
                     end
                     CALIBRATE: begin
                        motors_off   <= 1'b0;
                        inertial_cal <= 1'b1;
                        tmr          <= '0;
                        state        <= SPIN;
                     end
                     SET_PTCH, SET_ROLL, SET_YAW, SET_THRST, EMER_LAND, MTRS_OFF: begin
                        if (cmd == SET_PTCH)  d_ptch <= data[SP_W-1:0];
                        if (cmd == SET_ROLL)  d_roll <= data[SP_W-1:0];
                        if (cmd == SET_YAW)   d_yaw  <= data[SP_W-1:0];
                        if (cmd == SET_THRST) thrst  <= data[THR_W-1:0];
                        if (cmd == EMER_LAND) begin
                           d_ptch <= '0;
                           d_roll <= '0;
                           d_yaw  <= '0;
                           thrst  <= '0;
                        end
                        if (cmd == MTRS_OFF) motors_off <= 1'b1;
                        resp      <= ACK;
                        send_resp <= 1'b1;
                        state     <= WAIT_TX;
                     end
                     default: begin
                        resp      <= NACK;
                        send_resp <= 1'b1;
                        state     <= WAIT_TX;
                     end
                  endcase
               end
            end
            BATT: begin
               if (cnv_cmplt) begin
                  resp      <= batt;
                  send_resp <= 1'b1;
                  state     <= WAIT_TX;
               end
            end
            SPIN: begin
               if (tmr == TMR_MAX) begin
                  strt_cal <= 1'b1;
                  state    <= CAL;
               end else begin
                  tmr <= tmr + TMR_ONE;
               end
            end
            CAL: begin
               if (cal_done) begin
                  inertial_cal <= 1'b0;
                  resp         <= ACK;
                  send_resp    <= 1'b1;
                  state        <= WAIT_TX;
               end
            end
            WAIT_TX: begin
               if (resp_sent) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cmd_cfg_wd.sv
// Directed bench for cmd_cfg_wd with a small spin-up timer and watchdog.
module tb_cmd_cfg_wd;
   localparam int TMR_W = 9;
   localparam int SP_W  = 16;
   localparam int THR_W = 9;
   localparam int WD_W  = 10;

   logic             clk = 1'b0;
   logic             rst;
   logic             cmd_rdy;
   logic [7:0]       cmd;
   logic [15:0]      data;
   logic             clr_cmd_rdy;
   logic [7:0]       resp;
   logic             send_resp;
   logic             resp_sent;
   logic [7:0]       batt;
   logic             strt_cnv;
   logic             cnv_cmplt;
   logic             strt_cal;
   logic             inertial_cal;
   logic             cal_done;
   logic             motors_off;
   logic [SP_W-1:0]  d_ptch;
   logic [SP_W-1:0]  d_roll;
   logic [SP_W-1:0]  d_yaw;
   logic [THR_W-1:0] thrst;
   logic             wd_trip;

   int vectors     = 0;
   int miscompares = 0;

   cmd_cfg_wd #(.TMR_W(TMR_W), .SP_W(SP_W), .THR_W(THR_W), .WD_W(WD_W)) dut (
      .clk(clk), .rst(rst), .cmd_rdy(cmd_rdy), .cmd(cmd), .data(data),
      .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp),
      .resp_sent(resp_sent), .batt(batt), .strt_cnv(strt_cnv),
      .cnv_cmplt(cnv_cmplt), .strt_cal(strt_cal), .inertial_cal(inertial_cal),
      .cal_done(cal_done), .motors_off(motors_off), .d_ptch(d_ptch),
      .d_roll(d_roll), .d_yaw(d_yaw), .thrst(thrst), .wd_trip(wd_trip)
   );

   // clock
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wrapper side: present a command, wait for clr_cmd_rdy, drop cmd_rdy on that edge.
   task automatic issue(input logic [7:0] c, input logic [15:0] d);
      int n = 0;
      cmd = c; data = d; cmd_rdy = 1'b1;
      #1;
      while (!clr_cmd_rdy && n < 40) begin
         tick();
         n++;
      end
      vectors++;
      if (clr_cmd_rdy !== 1'b1) begin
         miscompares++;
         $display("FAIL issue_%h: clr_cmd_rdy=%b required 1", c, clr_cmd_rdy);
      end
      tick();
      cmd_rdy = 1'b0;
   endtask

   task automatic ack_resp();
      resp_sent = 1'b1;
      tick();
      resp_sent = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) tick();
      vectors++;
      if ({resp, motors_off, wd_trip, send_resp, strt_cnv, strt_cal, inertial_cal, clr_cmd_rdy} !== {8'h00, 7'b1000000}) begin
         miscompares++;
         $display("FAIL reset_ctrl: got %h/%b%b%b%b%b%b%b required 00/1000000", resp, motors_off, wd_trip,
                  send_resp, strt_cnv, strt_cal, inertial_cal, clr_cmd_rdy);
      end
      rst = 1'b0;
      tick();
      vectors++;
      if ({d_ptch, d_roll, d_yaw, thrst, motors_off} !== {57'd0, 1'b1}) begin
         miscompares++;
         $display("FAIL reset_sp: got %h %h %h %h mo=%b required 0 0 0 0 mo=1", d_ptch, d_roll, d_yaw, thrst, motors_off);
      end
   endtask

   task automatic test_batt();
      int bad = 0;
      batt = 8'h21;
      issue(8'h01, 16'h0000);
      vectors++;
      if ({strt_cnv, send_resp} !== 2'b10) begin
         miscompares++;
         $display("FAIL batt_strt_cnv: strt_cnv/send_resp=%b%b required 10", strt_cnv, send_resp);
      end
      tick();
      vectors++;
      if (strt_cnv !== 1'b0) begin
         miscompares++;
         $display("FAIL batt_cnv_pulse: strt_cnv=%b required 0", strt_cnv);
      end
      tick();
      tick();
      cnv_cmplt = 1'b1;
      vectors++;
      if (send_resp !== 1'b0) begin
         miscompares++;
         $display("FAIL batt_early_resp: send_resp=%b required 0", send_resp);
      end
      tick();
      cnv_cmplt = 1'b0;
      batt = 8'h77;
      vectors++;
      if ({send_resp, resp} !== {1'b1, 8'h21}) begin
         miscompares++;
         $display("FAIL batt_resp: send_resp=%b resp=%h required 1 21", send_resp, resp);
      end
      // New command held while the response is still in flight.
      cmd = 8'h02; data = 16'h0077; cmd_rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         if (clr_cmd_rdy !== 1'b0) bad++;
         tick();
      end
      resp_sent = 1'b1;
      #1;
      if (clr_cmd_rdy !== 1'b0) bad++;
      vectors++;
      if (bad !== 0) begin
         miscompares++;
         $display("FAIL batt_wait_tx: clr_cmd_rdy high in %0d cycles required 0", bad);
      end
      tick();
      resp_sent = 1'b0;
      vectors++;
      if (clr_cmd_rdy !== 1'b1) begin
         miscompares++;
         $display("FAIL batt_next_dispatch: clr_cmd_rdy=%b required 1", clr_cmd_rdy);
      end
      tick();
      cmd_rdy = 1'b0;
      vectors++;
      if ({send_resp, resp, d_ptch} !== {1'b1, 8'hA5, 16'h0077}) begin
         miscompares++;
         $display("FAIL batt_queued_cmd: send_resp=%b resp=%h d_ptch=%h required 1 a5 0077", send_resp, resp, d_ptch);
      end
      ack_resp();
   endtask

   task automatic test_setpoints();
      logic [7:0]  tc[5] = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h05};
      logic [15:0] td[5] = '{16'h0006, 16'h0004, 16'h0002, 16'hFF08, 16'h0008};
      logic [15:0] te[5] = '{16'h0006, 16'h0004, 16'h0002, 16'h0108, 16'h0008};
      logic [15:0] obs;
      for (int i = 0; i < 5; i++) begin
         issue(tc[i], td[i]);
         case (tc[i])
            8'h02:   obs = d_ptch;
            8'h03:   obs = d_roll;
            8'h04:   obs = d_yaw;
            default: obs = {7'd0, thrst};
         endcase
         vectors++;
         if ({send_resp, resp, obs} !== {1'b1, 8'hA5, te[i]}) begin
            miscompares++;
            $display("FAIL set_%0d: send_resp=%b resp=%h sp=%h required 1 a5 %h", i, send_resp, resp, obs, te[i]);
         end
         ack_resp();
         vectors++;
         if (send_resp !== 1'b0) begin
            miscompares++;
            $display("FAIL set_pulse_%0d: send_resp=%b required 0", i, send_resp);
         end
      end
      vectors++;
      if ({d_ptch, d_roll, d_yaw, thrst} !== {16'd6, 16'd4, 16'd2, 9'd8}) begin
         miscompares++;
         $display("FAIL set_all: %h %h %h %h required 0006 0004 0002 008", d_ptch, d_roll, d_yaw, thrst);
      end
   endtask

   task automatic test_calibrate();
      int n = 0;
      issue(8'h06, 16'h0000);
      vectors++;
      if ({motors_off, inertial_cal, send_resp} !== 3'b010) begin
         miscompares++;
         $display("FAIL cal_start: mo/ical/send=%b%b%b required 010", motors_off, inertial_cal, send_resp);
      end
      while (!strt_cal && n < 600) begin
         tick();
         n++;
      end
      vectors++;
      if (n !== 512) begin
         miscompares++;
         $display("FAIL cal_spin_len: strt_cal after %0d cycles required 512", n);
      end
      tick();
      vectors++;
      if ({strt_cal, inertial_cal} !== 2'b01) begin
         miscompares++;
         $display("FAIL cal_pulse: strt_cal/ical=%b%b required 01", strt_cal, inertial_cal);
      end
      repeat (4) tick();
      cal_done = 1'b1;
      vectors++;
      if ({inertial_cal, send_resp} !== 2'b10) begin
         miscompares++;
         $display("FAIL cal_hold: ical/send=%b%b required 10", inertial_cal, send_resp);
      end
      tick();
      cal_done = 1'b0;
      vectors++;
      if ({inertial_cal, send_resp, resp} !== {2'b01, 8'hA5}) begin
         miscompares++;
         $display("FAIL cal_done: ical=%b send=%b resp=%h required 0 1 a5", inertial_cal, send_resp, resp);
      end
      ack_resp();
   endtask

   task automatic test_emer_land();
      logic [7:0]  tc[4] = '{8'h02, 8'h03, 8'h04, 8'h05};
      logic [15:0] td[4] = '{16'h0006, 16'h0004, 16'h0002, 16'h0008};
      for (int i = 0; i < 4; i++) begin
         issue(tc[i], td[i]);
         ack_resp();
      end
      issue(8'h07, 16'hFFFF);
      vectors++;
      if ({d_ptch, d_roll, d_yaw, thrst} !== 57'd0) begin
         miscompares++;
         $display("FAIL emer_sp: %h %h %h %h required 0 0 0 0", d_ptch, d_roll, d_yaw, thrst);
      end
      vectors++;
      if ({motors_off, send_resp, resp} !== {2'b01, 8'hA5}) begin
         miscompares++;
         $display("FAIL emer_resp: mo=%b send=%b resp=%h required 0 1 a5", motors_off, send_resp, resp);
      end
      ack_resp();
      issue(8'h08, 16'h0000);
      vectors++;
      if ({motors_off, send_resp, resp} !== {2'b11, 8'hA5}) begin
         miscompares++;
         $display("FAIL mtrs_off: mo=%b send=%b resp=%h required 1 1 a5", motors_off, send_resp, resp);
      end
      ack_resp();
   endtask

   task automatic test_unknown();
      issue(8'h02, 16'h0006);
      ack_resp();
      issue(8'h3C, 16'h1234);
      vectors++;
      if ({send_resp, resp} !== {1'b1, 8'hEE}) begin
         miscompares++;
         $display("FAIL unknown_resp: send=%b resp=%h required 1 ee", send_resp, resp);
      end
      vectors++;
      if ({d_ptch, d_roll, d_yaw, thrst} !== {16'd6, 16'd0, 16'd0, 9'd0}) begin
         miscompares++;
         $display("FAIL unknown_sp: %h %h %h %h required 0006 0 0 0", d_ptch, d_roll, d_yaw, thrst);
      end
      ack_resp();
   endtask

   task automatic test_watchdog();
      int   n = 0;
      logic saw_resp = 1'b0;
      test_calibrate();
      issue(8'h02, 16'h0006);
      ack_resp();
      issue(8'h05, 16'h0008);
      vectors++;
      if ({thrst, wd_trip} !== {9'd8, 1'b0}) begin
         miscompares++;
         $display("FAIL wd_setup: thrst=%h wd_trip=%b required 008 0", thrst, wd_trip);
      end
      ack_resp();
      n = 1;
      while (!wd_trip && n < 1100) begin
         tick();
         n++;
         if (send_resp) saw_resp = 1'b1;
      end
      vectors++;
      if (n !== 1023) begin
         miscompares++;
         $display("FAIL wd_len: wd_trip after %0d cycles required 1023", n);
      end
      vectors++;
      if ({d_ptch, d_roll, d_yaw, thrst, motors_off, saw_resp} !== 59'd0) begin
         miscompares++;
         $display("FAIL wd_effect: %h %h %h %h mo=%b resp_seen=%b required 0 0 0 0 0 0", d_ptch, d_roll, d_yaw,
                  thrst, motors_off, saw_resp);
      end
      issue(8'h05, 16'h0005);
      vectors++;
      if ({wd_trip, thrst, send_resp, resp} !== {1'b0, 9'd5, 1'b1, 8'hA5}) begin
         miscompares++;
         $display("FAIL wd_recover: trip=%b thrst=%h send=%b resp=%h required 0 005 1 a5", wd_trip, thrst, send_resp, resp);
      end
      ack_resp();
   endtask

   task automatic test_reset_spin();
      issue(8'h06, 16'h0000);
      repeat (10) tick();
      vectors++;
      if ({motors_off, inertial_cal} !== 2'b01) begin
         miscompares++;
         $display("FAIL spin_pre: mo/ical=%b%b required 01", motors_off, inertial_cal);
      end
      rst = 1'b1;
      #1;
      vectors++;
      if ({motors_off, inertial_cal, thrst, resp, wd_trip} !== {2'b10, 9'd0, 8'h00, 1'b0}) begin
         miscompares++;
         $display("FAIL spin_rst: mo=%b ical=%b thrst=%h resp=%h trip=%b required 1 0 000 00 0", motors_off,
                  inertial_cal, thrst, resp, wd_trip);
      end
      tick();
      rst = 1'b0;
      tick();
      issue(8'h04, 16'h0002);
      vectors++;
      if ({send_resp, resp, d_yaw, motors_off} !== {1'b1, 8'hA5, 16'h0002, 1'b1}) begin
         miscompares++;
         $display("FAIL spin_after: send=%b resp=%h d_yaw=%h mo=%b required 1 a5 0002 1", send_resp, resp, d_yaw,
                  motors_off);
      end
      ack_resp();
   endtask

   initial begin
      rst = 1'b1; cmd_rdy = 1'b0; cmd = 8'h00; data = 16'h0000; resp_sent = 1'b0;
      batt = 8'h00; cnv_cmplt = 1'b0; cal_done = 1'b0;
      test_reset();
      test_batt();
      test_setpoints();
      test_calibrate();
      test_emer_land();
      test_unknown();
      test_watchdog();
      test_reset_spin();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
